ibus_imem_responder: RTL and testbench

Instruction-memory responder for the core's iBus: the target end of the fetch protocol the `riscv` core initiates. It accepts one fetch command at a time and looks up a word in an internal instruction RAM. After a programmable number of wait states it returns the instruction word, or an error, on the iBus response channel. A side-band program port lets the bench or boot logic load the RAM.

---
 rtl/ibus_imem_responder.sv | 121 ++++++++++++
 tb/tb_ibus_imem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_imem_responder.sv
// rtl/ibus_imem_responder.sv - iBus instruction-memory responder with wait states and program port
// Optional build macro: IBUS_IMEM_MISALIGN_CHECK_EN (reject fetches with pc[1:0] != 0).
module ibus_imem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstf,
    input  logic          iBus_cmd_valid,
    output logic          iBus_cmd_ready,
    input  logic [31:0]   iBus_cmd_payload_pc,
    output logic          iBus_rsp_ready,
    output logic          iBus_rsp_err,
    output logic [31:0]   iBus_rsp_inst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        r_pend_err;
    logic [31:0] r_pend_inst;
    logic        r_rsp_err;
    logic [31:0] r_rsp_inst;
    logic [31:0] r_mem [DEPTH];

    logic          w_hs;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    logic          w_range_err;
    logic          w_fetch_err;
    logic [31:0]   w_fetch_inst;

    assign iBus_cmd_ready = rstf && (r_state != S_WAIT);
    assign iBus_rsp_ready = (r_state == S_RESP);
    assign iBus_rsp_err   = r_rsp_err;
    assign iBus_rsp_inst  = r_rsp_inst;

    assign w_hs        = iBus_cmd_valid && iBus_cmd_ready;
    assign w_idx       = iBus_cmd_payload_pc[AW+1:2];
    assign w_rd_data   = r_mem[w_idx];
    assign w_range_err = (iBus_cmd_payload_pc >= (32'(DEPTH) << 2));

`ifdef IBUS_IMEM_MISALIGN_CHECK_EN
    assign w_fetch_err = w_range_err || (iBus_cmd_payload_pc[1:0] != 2'b00);
`else
    assign w_fetch_err = w_range_err;
`endif

    assign w_fetch_inst = w_fetch_err ? 32'h0 : w_rd_data;

    // Plain write port, no reset: contents survive rstf. Reads above see pre-write data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_next_state = S_IDLE;
                if (w_hs) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Response data is captured at accept into r_pend_*, and only moved to the
    // visible output registers on entry to RESP so outputs hold between responses.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_pend_err  <= 1'b0;
            r_pend_inst <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rsp_inst  <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_hs) begin
                r_pend_err  <= w_fetch_err;
                r_pend_inst <= w_fetch_inst;
            end
            if (w_next_state == S_RESP) begin
                r_rsp_err  <= w_hs ? w_fetch_err  : r_pend_err;
                r_rsp_inst <= w_hs ? w_fetch_inst : r_pend_inst;
            end
        end
    end

endmodule

// File: tb/tb_ibus_imem_responder.sv
// tb/tb_ibus_imem_responder.sv - bench for ibus_imem_responder (WAIT_CYCLES 0 and 3 instances)
module tb_ibus_imem_responder;

    logic        clk = 1'b0;
    logic        rstf;
    logic        v   [2];
    logic [31:0] pcs [2];
    logic        cr  [2];
    logic        rr  [2];
    logic        re  [2];
    logic [31:0] ri  [2];
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ibus_imem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstf(rstf),
        .iBus_cmd_valid(v[0]), .iBus_cmd_ready(cr[0]), .iBus_cmd_payload_pc(pcs[0]),
        .iBus_rsp_ready(rr[0]), .iBus_rsp_err(re[0]), .iBus_rsp_inst(ri[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    ibus_imem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rstf(rstf),
        .iBus_cmd_valid(v[1]), .iBus_cmd_ready(cr[1]), .iBus_cmd_payload_pc(pcs[1]),
        .iBus_rsp_ready(rr[1]), .iBus_rsp_err(re[1]), .iBus_rsp_inst(ri[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: edge-indexed timeline. Accept at edge N -> busy until N+W, response in cycle after N+W.
    int          cyc = 0;
    logic [31:0] m_mem [1024];
    int          m_busy [2];
    int          m_rsp_edge [2];
    logic        m_perr [2];
    logic [31:0] m_pinst [2];
    logic        m_err [2];
    logic [31:0] m_inst [2];

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_rsp_edge[d] = -1;
            m_perr[d] = 1'b0; m_pinst[d] = 32'h0; m_err[d] = 1'b0; m_inst[d] = 32'h0;
        end
    end

    always @(posedge clk) begin
        logic        perr;
        logic [31:0] pc;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rstf) begin
                m_busy[d] = 0; m_rsp_edge[d] = -1; m_err[d] = 1'b0; m_inst[d] = 32'h0;
            end else begin
                if (v[d] && (cyc - 1 >= m_busy[d])) begin
                    pc   = pcs[d];
                    perr = (pc >= 32'd4096);
`ifdef IBUS_IMEM_MISALIGN_CHECK_EN
                    if (pc % 4 != 0) perr = 1'b1;
`endif
                    m_perr[d]     = perr;
                    m_pinst[d]    = perr ? 32'h0 : m_mem[(pc / 4) % 1024];
                    m_busy[d]     = cyc + wait_of(d);
                    m_rsp_edge[d] = cyc + wait_of(d);
                end
                if (cyc == m_rsp_edge[d]) begin
                    m_err[d]  = m_perr[d];
                    m_inst[d] = m_pinst[d];
                end
            end
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d cmd_ready cyc%0d", d, cyc), {31'h0, cr[d]},
                    {31'h0, rstf && (cyc >= m_busy[d])});
                chk($sformatf("d%0d rsp_ready cyc%0d", d, cyc), {31'h0, rr[d]},
                    {31'h0, rstf && (cyc == m_rsp_edge[d])});
                chk($sformatf("d%0d rsp_err cyc%0d", d, cyc), {31'h0, re[d]},
                    {31'h0, rstf && m_err[d]});
                chk($sformatf("d%0d rsp_inst cyc%0d", d, cyc), ri[d],
                    rstf ? m_inst[d] : 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [9:0] a, input logic [31:0] dat);
        prog_we = 1'b1; prog_addr = a; prog_data = dat;
        tick();
        prog_we = 1'b0;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h00000013; words[1] = 32'h00100093;
        words[2] = 32'h00200113; words[3] = 32'h00300193;
        rstf = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int d = 0; d < 2; d++) begin v[d] = 1'b0; pcs[d] = 32'h0; end

        tick(); tick(); tick();
        chk("reset cmd_ready", {31'h0, cr[0]}, 32'h0);
        chk("reset rsp_ready", {31'h0, rr[1]}, 32'h0);
        rstf = 1'b1;
        #1;
        chk("cmd_ready after release", {31'h0, cr[0]}, 32'h1);

        for (int i = 0; i < 4; i++) prog(10'(i), words[i]);
        prog(10'd1023, 32'hCAFEF00D);
        tick();

        // Back-to-back fetches, zero wait states
        v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pcs[0] = 32'(i * 4);
            tick();
            chk($sformatf("b2b rsp_ready %0d", i), {31'h0, rr[0]}, 32'h1);
            chk($sformatf("b2b inst %0d", i), ri[0], words[i]);
        end
        v[0] = 1'b0;
        tick();

        // Three wait states, valid held so a second fetch is taken in RESP
        v[1] = 1'b1; pcs[1] = 32'h4;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w3 cmd_ready low %0d", i), {31'h0, cr[1]}, 32'h0);
            tick();
        end
        chk("w3 rsp_ready", {31'h0, rr[1]}, 32'h1);
        chk("w3 inst", ri[1], 32'h00100093);
        chk("w3 ready in resp", {31'h0, cr[1]}, 32'h1);
        tick();
        v[1] = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Range boundary
        v[0] = 1'b1; pcs[0] = 32'h00001000;
        tick();
        chk("range err", {31'h0, re[0]}, 32'h1);
        chk("range inst", ri[0], 32'h0);
        pcs[0] = 32'h00000FFC;
        tick();
        chk("last word err", {31'h0, re[0]}, 32'h0);
        chk("last word inst", ri[0], 32'hCAFEF00D);

        // Misaligned fetch
        pcs[0] = 32'h2;
        tick();
`ifdef IBUS_IMEM_MISALIGN_CHECK_EN
        chk("misalign err", {31'h0, re[0]}, 32'h1);
        chk("misalign inst", ri[0], 32'h0);
`else
        chk("misalign err", {31'h0, re[0]}, 32'h0);
        chk("misalign inst", ri[0], 32'h00000013);
`endif

        // Same-edge program write and fetch of word 1
        pcs[0] = 32'h4;
        prog_we = 1'b1; prog_addr = 10'd1; prog_data = 32'hDEADBEEF;
        tick();
        prog_we = 1'b0;
        chk("rbw old data", ri[0], 32'h00100093);
        tick();
        chk("rbw new data", ri[0], 32'hDEADBEEF);
        v[0] = 1'b0;
        tick();

        // Reset during WAIT aborts the fetch
        v[1] = 1'b1; pcs[1] = 32'h8;
        tick();
        v[1] = 1'b0;
        tick();
        rstf = 1'b0;
        #1;
        chk("abort cmd_ready", {31'h0, cr[1]}, 32'h0);
        chk("abort rsp_ready", {31'h0, rr[1]}, 32'h0);
        chk("abort inst", ri[1], 32'h0);
        tick(); tick();
        rstf = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        v[1] = 1'b1; pcs[1] = 32'hC;
        tick();
        v[1] = 1'b0;
        tick(); tick(); tick();
        chk("retain rsp_ready", {31'h0, rr[1]}, 32'h1);
        chk("retain inst", ri[1], 32'h00300193);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
